// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular reorder buffer that sits between dispatch and architectural state.
//   Entries are allocated at the tail (the allocated tag is ROB_Tail). The
//   common data bus marks them done. They retire strictly in order from the
//   head, at most one per cycle. When a mispredicted entry retires, the buffer
//   raises clr for one cycle with the redirect PC and is emptied on the
//   following cycle.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     rdy                      low = pause: state holds, pulse outputs read 0
//     dispatch_valid/rd/name   decoded entry offered for allocation
//     success, ROB_Tail        allocation possible / tag of next allocation
//     cdb_valid/tag/value/     completion broadcast, with mispredict flag and
//       mispredict/target        corrected target PC
//     ROB_Ready/Addr/Value/Tag register-update broadcast on commit
//     store_commit, store_tag  head store retired
//     clr, redirect_pc         flush pulse and fetch redirect target
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ROB_SIZE   = 16,
  parameter int ROB_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  dispatch_valid,
  input  logic [DATA_WIDTH-1:0] dispatch_rd,
  input  logic [16:0]           dispatch_name,
  output logic                  success,
  output logic [ROB_WIDTH-1:0]  ROB_Tail,
  input  logic                  cdb_valid,
  input  logic [ROB_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_value,
  input  logic                  cdb_mispredict,
  input  logic [DATA_WIDTH-1:0] cdb_target,
  output logic                  ROB_Ready,
  output logic [4:0]            ROB_Addr,
  output logic [DATA_WIDTH-1:0] ROB_Value,
  output logic [ROB_WIDTH-1:0]  ROB_Tag,
  output logic                  store_commit,
  output logic [ROB_WIDTH-1:0]  store_tag,
  output logic                  clr,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    CLS_REG    = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_STORE  = 2'd2
  } rob_class_e;

  typedef struct packed {
    logic [4:0]            rd;
    rob_class_e            cls;
    logic [DATA_WIDTH-1:0] value;
    logic                  mispredict;
    logic [DATA_WIDTH-1:0] target;
  } rob_payload_t;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [ROB_WIDTH:0] COUNT_FULL = (ROB_WIDTH+1)'(ROB_SIZE);

  // Control state
  logic [ROB_WIDTH-1:0] head_q, tail_q;
  logic [ROB_WIDTH:0]   count_q;
  logic [ROB_SIZE-1:0]  busy_q, done_q;
  logic                 ready_q, store_q, clr_q;

  // Entry payload
  rob_payload_t payload_q [ROB_SIZE];
  rob_payload_t head_entry;

  logic       full;
  logic       dispatch_accept;
  logic       cdb_accept;
  logic       commit;
  rob_class_e dispatch_class;

  // Only rd[4:0] and the opcode field carry information.
  logic unused_bits;
  assign unused_bits = ^{dispatch_rd[DATA_WIDTH-1:5], dispatch_name[9:0]};

  always_comb begin
    dispatch_class = CLS_REG;
    if (dispatch_name[16:10] == OPC_BRANCH)     dispatch_class = CLS_BRANCH;
    else if (dispatch_name[16:10] == OPC_STORE) dispatch_class = CLS_STORE;
  end

  assign head_entry = payload_q[head_q];
  assign full       = (count_q == COUNT_FULL);
  // A full buffer refuses dispatch even when the head retires in the same cycle.
  assign success    = !full && !clr_q;

  assign dispatch_accept = rdy && dispatch_valid && success;
  // The flush cycle ignores completions and commits, so younger entries
  // that are already done can never retire past a mispredict.
  assign cdb_accept      = rdy && !clr_q && cdb_valid && busy_q[cdb_tag];
  assign commit          = rdy && !clr_q && busy_q[head_q] && done_q[head_q];

  assign ROB_Tail     = tail_q;
  // Pulses are held internally across a pause and are shown only while rdy is high.
  assign ROB_Ready    = ready_q && rdy;
  assign store_commit = store_q && rdy;
  assign clr          = clr_q && rdy;

  // NOTE: the payload array has no reset; busy_q gates every read, so stale
  // contents are never observed and the storage can stay plain RAM.
  always_ff @(posedge clk) begin
    if (dispatch_accept) begin
      payload_q[tail_q].rd  <= dispatch_rd[4:0];
      payload_q[tail_q].cls <= dispatch_class;
    end
    if (cdb_accept) begin
      payload_q[cdb_tag].value      <= cdb_value;
      payload_q[cdb_tag].mispredict <= cdb_mispredict;
      payload_q[cdb_tag].target     <= cdb_target;
    end
  end

  // NOTE: non-blocking assignments throughout, so every branch below reads
  // the pre-edge state regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      done_q       <= '0;
      ready_q      <= 1'b0;
      store_q      <= 1'b0;
      clr_q        <= 1'b0;
      ROB_Addr     <= '0;
      ROB_Value    <= '0;
      ROB_Tag      <= '0;
      store_tag    <= '0;
      redirect_pc  <= '0;
    end else if (rdy) begin
      ready_q <= 1'b0;
      store_q <= 1'b0;
      clr_q   <= 1'b0;
      if (clr_q) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        busy_q  <= '0;
        done_q  <= '0;
      end else begin
        if (dispatch_accept) begin
          busy_q[tail_q] <= 1'b1;
          done_q[tail_q] <= 1'b0;
          tail_q         <= tail_q + 1'b1;
        end
        if (cdb_accept) begin
          done_q[cdb_tag] <= 1'b1;
        end
        if (commit) begin
          busy_q[head_q] <= 1'b0;
          done_q[head_q] <= 1'b0;
          head_q         <= head_q + 1'b1;
          if (head_entry.cls == CLS_REG && head_entry.rd != 5'd0) begin
            ready_q   <= 1'b1;
            ROB_Addr  <= head_entry.rd;
            ROB_Value <= head_entry.value;
            ROB_Tag   <= head_q;
          end
          if (head_entry.cls == CLS_STORE) begin
            store_q   <= 1'b1;
            store_tag <= head_q;
          end
          if (head_entry.mispredict) begin
            clr_q       <= 1'b1;
            redirect_pc <= head_entry.target;
          end
        end
        case ({dispatch_accept, commit})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed bench for reorder_buffer: a vector table for in-order commit,
//   store and rd=0 retirement and ignored completions, then hand sequences for
//   the full/wrap boundary, mispredict flush, reset mid-operation and pause.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam logic [16:0] N_ADDI   = {7'b0010011, 3'b000, 7'b0};
  localparam logic [16:0] N_BRANCH = {7'b1100011, 3'b000, 7'b0};
  localparam logic [16:0] N_STORE  = {7'b0100011, 3'b010, 7'b0};

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        dispatch_valid;
  logic [31:0] dispatch_rd;
  logic [16:0] dispatch_name;
  logic        success;
  logic [3:0]  ROB_Tail;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic        ROB_Ready;
  logic [4:0]  ROB_Addr;
  logic [31:0] ROB_Value;
  logic [3:0]  ROB_Tag;
  logic        store_commit;
  logic [3:0]  store_tag;
  logic        clr;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dispatch_valid(dispatch_valid), .dispatch_rd(dispatch_rd),
    .dispatch_name(dispatch_name), .success(success), .ROB_Tail(ROB_Tail),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .ROB_Ready(ROB_Ready), .ROB_Addr(ROB_Addr), .ROB_Value(ROB_Value),
    .ROB_Tag(ROB_Tag), .store_commit(store_commit), .store_tag(store_tag),
    .clr(clr), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  rd;
    logic [16:0] name;
    logic        cv;
    logic [3:0]  ctag;
    logic [31:0] cval;
    logic        e_success;
    logic [3:0]  e_tail;
    logic        e_ready;
    logic [4:0]  e_addr;
    logic [31:0] e_value;
    logic [3:0]  e_rtag;
    logic        e_store;
    logic [3:0]  e_stag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic dv, logic [4:0] rd, logic [16:0] name,
                              logic cv, logic [3:0] ctag, logic [31:0] cval,
                              logic [3:0] e_tail, logic e_ready, logic [4:0] e_addr,
                              logic [31:0] e_value, logic [3:0] e_rtag,
                              logic e_store, logic [3:0] e_stag);
    vec_t v;
    v.dv = dv; v.rd = rd; v.name = name;
    v.cv = cv; v.ctag = ctag; v.cval = cval;
    v.e_success = 1'b1; v.e_tail = e_tail;
    v.e_ready = e_ready; v.e_addr = e_addr; v.e_value = e_value; v.e_rtag = e_rtag;
    v.e_store = e_store; v.e_stag = e_stag;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_valid = 1'b0; dispatch_rd = '0; dispatch_name = N_ADDI;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    cdb_mispredict = 1'b0; cdb_target = '0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [16:0] name);
    idle_inputs();
    dispatch_valid = 1'b1; dispatch_rd = {27'b0, rd}; dispatch_name = name;
    step();
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val,
                     input logic mis, input logic [31:0] tgt);
    idle_inputs();
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
    cdb_mispredict = mis; cdb_target = tgt;
    step();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_reg_commit(input string name, input logic [4:0] addr,
                                  input logic [31:0] val, input logic [3:0] tag);
    check({name, " ready"}, ROB_Ready, 1);
    check({name, " addr"}, ROB_Addr, addr);
    check({name, " value"}, ROB_Value, val);
    check({name, " tag"}, ROB_Tag, tag);
  endtask

  initial begin
    rdy = 1'b1;
    do_reset();

    // Reset state
    check("rst success", success, 1);
    check("rst tail", ROB_Tail, 0);
    check("rst ready", ROB_Ready, 0);
    check("rst store", store_commit, 0);
    check("rst clr", clr, 0);
    check("rst redirect", redirect_pc, 0);

    //                dv rd  name      cv tag val        tail rdy addr val        rtag st stag
    vecs.push_back(mk(1, 5,  N_ADDI,   0, 0, 0,         1,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(1, 6,  N_ADDI,   0, 0, 0,         2,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(1, 7,  N_ADDI,   0, 0, 0,         3,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         3,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   1, 1, 32'h22,    3,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   1, 0, 32'h11,    3,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         3,   1,  5,   32'h11,    0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         3,   1,  6,   32'h22,    1,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         3,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(1, 0,  N_STORE,  0, 0, 0,         4,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(1, 0,  N_ADDI,   0, 0, 0,         5,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(1, 9,  N_ADDI,   1, 2, 32'h77,    6,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   1, 3, 32'h0,     6,   1,  7,   32'h77,    2,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   1, 4, 32'h55,    6,   0,  0,   0,         0,   1, 3));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         6,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   1, 5, 32'h99,    6,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         6,   1,  9,   32'h99,    5,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   1, 7, 32'hdead,  6,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(1, 3,  N_ADDI,   0, 0, 0,         7,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         7,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(1, 4,  N_ADDI,   0, 0, 0,         8,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   1, 6, 32'h66,    8,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         8,   1,  3,   32'h66,    6,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         8,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   1, 7, 32'h77,    8,   0,  0,   0,         0,   0, 0));
    vecs.push_back(mk(0, 0,  N_ADDI,   0, 0, 0,         8,   1,  4,   32'h77,    7,   0, 0));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      idle_inputs();
      dispatch_valid = vecs[i].dv;
      dispatch_rd    = {27'b0, vecs[i].rd};
      dispatch_name  = vecs[i].name;
      cdb_valid      = vecs[i].cv;
      cdb_tag        = vecs[i].ctag;
      cdb_value      = vecs[i].cval;
      step();
      check({tag, " success"}, success, vecs[i].e_success);
      check({tag, " tail"}, ROB_Tail, vecs[i].e_tail);
      check({tag, " ready"}, ROB_Ready, vecs[i].e_ready);
      check({tag, " store"}, store_commit, vecs[i].e_store);
      check({tag, " clr"}, clr, 0);
      if (vecs[i].e_ready) begin
        check({tag, " addr"}, ROB_Addr, vecs[i].e_addr);
        check({tag, " value"}, ROB_Value, vecs[i].e_value);
        check({tag, " rtag"}, ROB_Tag, vecs[i].e_rtag);
      end
      if (vecs[i].e_store) check({tag, " stag"}, store_tag, vecs[i].e_stag);
    end

    // Fill to 16 entries; tail wraps 15 -> 0 and success drops when full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp(5'(i + 1), N_ADDI);
      check($sformatf("fill%0d tail", i), ROB_Tail, (i + 1) % 16);
      check($sformatf("fill%0d success", i), success, (i < 15) ? 1 : 0);
    end
    // 17th dispatch dropped, head completes in the same cycle
    idle_inputs();
    dispatch_valid = 1'b1; dispatch_rd = 32'd20;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'hA0;
    step();
    check("full drop tail", ROB_Tail, 0);
    check("full drop success", success, 0);
    // Commit while full: dispatch still refused this cycle
    cdb_valid = 1'b0;
    step();
    check_reg_commit("full commit", 5'd1, 32'hA0, 4'd0);
    check("full commit tail", ROB_Tail, 0);
    check("full commit success", success, 1);
    disp(5'd21, N_ADDI);
    check("refill tail", ROB_Tail, 1);
    check("refill success", success, 0);
    cdb(4'd1, 32'hB1, 1'b0, 32'h0);
    check("full cdb success", success, 0);
    cdb(4'd2, 32'hB2, 1'b0, 32'h0);
    check_reg_commit("commit t1", 5'd2, 32'hB1, 4'd1);
    check("commit t1 success", success, 1);
    // Dispatch and commit in one cycle keeps the count at 15
    disp(5'd22, N_ADDI);
    check_reg_commit("dispcommit", 5'd3, 32'hB2, 4'd2);
    check("dispcommit tail", ROB_Tail, 2);
    check("dispcommit success", success, 1);
    disp(5'd23, N_ADDI);
    check("refull tail", ROB_Tail, 3);
    check("refull success", success, 0);

    // Mispredicted branch at tag 2 with younger done entries behind it
    do_reset();
    disp(5'd10, N_ADDI);
    disp(5'd11, N_ADDI);
    disp(5'd0,  N_BRANCH);
    disp(5'd12, N_ADDI);
    disp(5'd13, N_ADDI);
    check("mp tail", ROB_Tail, 5);
    cdb(4'd3, 32'h33, 1'b0, 32'h0);
    cdb(4'd4, 32'h44, 1'b0, 32'h0);
    cdb(4'd2, 32'h0, 1'b1, 32'h1000);
    cdb(4'd0, 32'h10, 1'b0, 32'h0);
    check("mp pre ready", ROB_Ready, 0);
    cdb(4'd1, 32'h11, 1'b0, 32'h0);
    check_reg_commit("mp t0", 5'd10, 32'h10, 4'd0);
    idle_inputs();
    step();
    check_reg_commit("mp t1", 5'd11, 32'h11, 4'd1);
    check("mp t1 clr", clr, 0);
    step();
    check("mp clr", clr, 1);
    check("mp redirect", redirect_pc, 32'h1000);
    check("mp branch ready", ROB_Ready, 0);
    check("mp clr success", success, 0);
    // Offer a dispatch and a completion during the flush cycle; both ignored
    dispatch_valid = 1'b1; dispatch_rd = 32'd15;
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h99;
    step();
    check("flush clr", clr, 0);
    check("flush tail", ROB_Tail, 0);
    check("flush success", success, 1);
    check("flush ready", ROB_Ready, 0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post flush%0d ready", i), ROB_Ready, 0);
      check($sformatf("post flush%0d tail", i), ROB_Tail, 0);
    end

    // Reset mid-operation: 5 entries, one done, a CDB pending at the reset edge
    for (int i = 0; i < 5; i++) disp(5'(i + 1), N_ADDI);
    cdb(4'd0, 32'h5, 1'b0, 32'h0);
    idle_inputs();
    rst = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h6;
    step();
    rst = 1'b0;
    idle_inputs();
    check("midrst tail", ROB_Tail, 0);
    check("midrst success", success, 1);
    check("midrst ready", ROB_Ready, 0);
    check("midrst addr", ROB_Addr, 0);
    check("midrst value", ROB_Value, 0);
    check("midrst rtag", ROB_Tag, 0);
    check("midrst store", store_commit, 0);
    check("midrst clr", clr, 0);
    step();
    check("midrst idle ready", ROB_Ready, 0);

    // Pause: dispatch refused, commit held until rdy returns
    rdy = 1'b0;
    dispatch_valid = 1'b1; dispatch_rd = 32'd8;
    step();
    check("pause tail", ROB_Tail, 0);
    rdy = 1'b1;
    disp(5'd8, N_ADDI);
    check("unpause tail", ROB_Tail, 1);
    cdb(4'd0, 32'h88, 1'b0, 32'h0);
    rdy = 1'b0;
    step();
    check("pause ready", ROB_Ready, 0);
    rdy = 1'b1;
    step();
    check_reg_commit("resume", 5'd8, 32'h88, 4'd0);
    // Reset while paused still resets
    disp(5'd9, N_ADDI);
    check("prst pre tail", ROB_Tail, 2);
    idle_inputs();
    rdy = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rdy = 1'b1;
    check("paused rst tail", ROB_Tail, 0);
    check("paused rst success", success, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
